// File: rtl/dinv_debounce_if.sv
// Signal bundle between the raw-input conditioning stage and its consumer.
// The master side drives the raw level and enable. The slave side returns the debounced level and status.
interface dinv_debounce_if;
  logic       raw_in;
  logic       en;
  logic       a_out;
  logic       rise;
  logic       fall;
  logic       busy;
  logic [7:0] glitch_cnt;

  modport master (
    output raw_in,
    output en,
    input  a_out,
    input  rise,
    input  fall,
    input  busy,
    input  glitch_cnt
  );

  modport slave (
    input  raw_in,
    input  en,
    output a_out,
    output rise,
    output fall,
    output busy,
    output glitch_cnt
  );
endinterface

// File: rtl/dinv_debounce.sv
// Synchronises and debounces a raw asynchronous level feeding dinv.a.
// Also produces rise/fall pulses and a saturating count of rejected glitches.
module dinv_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic INIT_LEVEL      = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  dinv_debounce_if.slave bus
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;

  state_t     state_q, state_nxt;
  logic [7:0] cnt_q, cnt_nxt;
  logic       a_q, a_nxt;
  logic       rise_q, rise_nxt;
  logic       fall_q, fall_nxt;
  logic [7:0] glitch_q, glitch_nxt;

  // The synchroniser runs every cycle, independent of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], bus.raw_in};
    end
  end

  assign sync_q = sync_r[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_STABLE;
      cnt_q    <= '0;
      a_q      <= INIT_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= '0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      a_q      <= a_nxt;
      rise_q   <= rise_nxt;
      fall_q   <= fall_nxt;
      glitch_q <= glitch_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    a_nxt      = a_q;
    rise_nxt   = 1'b0;
    fall_nxt   = 1'b0;
    glitch_nxt = glitch_q;

    if (!bus.en) begin
      // Dropping en abandons any candidate without counting it as a glitch.
      state_nxt = ST_STABLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state_q)
        ST_STABLE: begin
          if (sync_q != a_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              a_nxt    = ~a_q;
              rise_nxt = ~a_q;
              fall_nxt = a_q;
            end else begin
              state_nxt = ST_CHECK;
              cnt_nxt   = 8'd1;
            end
          end
        end
        ST_CHECK: begin
          if (sync_q != a_q) begin
            if (cnt_q == CNT_LAST) begin
              a_nxt     = ~a_q;
              rise_nxt  = ~a_q;
              fall_nxt  = a_q;
              cnt_nxt   = '0;
              state_nxt = ST_STABLE;
            end else begin
              cnt_nxt = cnt_q + 8'd1;
            end
          end else begin
            cnt_nxt   = '0;
            state_nxt = ST_STABLE;
            if (glitch_q != '1) begin
              glitch_nxt = glitch_q + 8'd1;
            end
          end
        end
        default: begin
          state_nxt = ST_STABLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign bus.a_out      = a_q;
  assign bus.rise       = rise_q;
  assign bus.fall       = fall_q;
  assign bus.busy       = (state_q == ST_CHECK);
  assign bus.glitch_cnt = glitch_q;

endmodule
